// File: rtl/sensor_cmd_pkg.sv
// Shared definitions for the sensor request scheduler: protocol codes,
// FSM state encoding and the single-entry sample cache layout.
package sensor_cmd_pkg;

  localparam logic [7:0] REQ_STATUS = 8'h03;
  localparam logic [7:0] REQ_TEMP   = 8'h04;
  localparam logic [7:0] REQ_HUM    = 8'h05;

  localparam logic [7:0] RSP_STATUS_OK = 8'h08;
  localparam logic [7:0] RSP_TEMP      = 8'h09;
  localparam logic [7:0] RSP_HUM       = 8'h0A;
  localparam logic [7:0] RSP_FAULT     = 8'h1F;
  localparam logic [7:0] RSP_BAD_ADDR  = 8'hFE;
  localparam logic [7:0] RSP_UNKNOWN   = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_DECODE,
    ST_START,
    ST_WAIT_SENSOR,
    ST_BUILD,
    ST_SEND0,
    ST_HOLD0,
    ST_SEND1,
    ST_HOLD1
  } state_t;

  // The checksum is kept with the frame so the encoder can judge it later;
  // fault records bus errors and timeouts.
  typedef struct packed {
    logic       valid;
    logic       fault;
    logic [7:0] addr;
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
    logic [7:0] crc;
  } cache_entry_t;

  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/sensor_request_scheduler_if.sv
// Bundle of the UART, sensor-reader and transmitter signals seen by the scheduler.
interface sensor_request_scheduler_if;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic [7:0] o_sensor_addr;
  logic       o_sensor_start;
  logic       i_sensor_done;
  logic       i_sensor_error;
  logic [7:0] i_hum_int;
  logic [7:0] i_hum_float;
  logic [7:0] i_temp_int;
  logic [7:0] i_temp_float;
  logic [7:0] i_crc;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_busy;
  logic       o_busy;

  modport master (
    input  i_rx_valid, i_rx_data, i_sensor_done, i_sensor_error,
           i_hum_int, i_hum_float, i_temp_int, i_temp_float, i_crc, i_tx_busy,
    output o_sensor_addr, o_sensor_start, o_tx_data, o_tx_start, o_busy
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_sensor_done, i_sensor_error,
           i_hum_int, i_hum_float, i_temp_int, i_temp_float, i_crc, i_tx_busy,
    input  o_sensor_addr, o_sensor_start, o_tx_data, o_tx_start, o_busy
  );
endinterface

// File: rtl/sensor_resp_encoder.sv
// Turns a request code plus the cached sample into the two response bytes.
module sensor_resp_encoder
  import sensor_cmd_pkg::*;
(
  input  logic [7:0] req_code,
  input  logic       bad_addr,
  input  logic       fault,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic [7:0] crc,
  output logic [7:0] byte0,
  output logic [7:0] byte1
);

  logic bad_sample;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bad_sample = fault || (frame_sum(hum_int, hum_float, temp_int, temp_float) != crc);
    byte0 = RSP_UNKNOWN;
    byte1 = 8'h00;
    if (bad_addr) begin
      byte0 = RSP_BAD_ADDR;
    end else begin
      case (req_code)
        REQ_STATUS: byte0 = bad_sample ? RSP_FAULT : RSP_STATUS_OK;
        REQ_TEMP: if (bad_sample) byte0 = RSP_FAULT;
                  else begin byte0 = RSP_TEMP; byte1 = temp_int; end
        REQ_HUM:  if (bad_sample) byte0 = RSP_FAULT;
                  else begin byte0 = RSP_HUM; byte1 = hum_int; end
        default:  byte0 = RSP_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/sensor_request_scheduler.sv
// Parses two-byte UART sensor queries, refreshes a one-entry cache from the
// sensor reader when stale, and sends the two-byte answer to the transmitter.
module sensor_request_scheduler
  import sensor_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned READ_INTERVAL  = CLK_HZ,
  parameter int unsigned SENSOR_TIMEOUT = CLK_HZ / 10,
  parameter int unsigned RX_TIMEOUT     = CLK_HZ / 100,
  parameter int unsigned N_SENSORS      = 32
) (
  input logic                        clock,
  input logic                        reset_n,
  sensor_request_scheduler_if.master bus
);

  state_t       state, state_next;
  logic [7:0]   addr_q, code_q, resp0, resp1;
  logic [31:0]  timer, age;
  cache_entry_t cache;
  logic         bad_addr, code_known, hit, sensor_timeout, read_done;
  logic [7:0]   enc_byte0, enc_byte1;

  assign bad_addr       = 32'(addr_q) >= N_SENSORS;
  assign code_known     = code_q inside {REQ_STATUS, REQ_TEMP, REQ_HUM};
  assign hit            = cache.valid && (cache.addr == addr_q) && (age < READ_INTERVAL);
  assign sensor_timeout = (state == ST_WAIT_SENSOR) && !bus.i_sensor_done
                          && (timer == SENSOR_TIMEOUT - 1);
  assign read_done      = (state == ST_WAIT_SENSOR) && (bus.i_sensor_done || sensor_timeout);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.o_sensor_start = 1'b0;
    bus.o_tx_start     = 1'b0;
    case (state)
      ST_IDLE:        if (bus.i_rx_valid) state_next = ST_GET_CMD;
      ST_GET_CMD:     if (bus.i_rx_valid) state_next = ST_DECODE;
                      else if (timer == RX_TIMEOUT - 1) state_next = ST_IDLE;
      ST_DECODE:      state_next = (bad_addr || !code_known || hit) ? ST_BUILD : ST_START;
      ST_START: begin
        bus.o_sensor_start = 1'b1;
        state_next         = ST_WAIT_SENSOR;
      end
      ST_WAIT_SENSOR: if (read_done) state_next = ST_BUILD;
      ST_BUILD:       state_next = ST_SEND0;
      ST_SEND0:       if (!bus.i_tx_busy) begin
                        bus.o_tx_start = 1'b1;
                        state_next     = ST_HOLD0;
                      end
      // The transmitter may raise busy a cycle late, so the first hold cycle
      // never looks at it.
      ST_HOLD0:       if (timer != 0 && !bus.i_tx_busy) state_next = ST_SEND1;
      ST_SEND1:       if (!bus.i_tx_busy) begin
                        bus.o_tx_start = 1'b1;
                        state_next     = ST_HOLD1;
                      end
      ST_HOLD1:       if (timer != 0 && !bus.i_tx_busy) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // NOTE: the cache is a single register entry, not a memory array, so it is
  // reset like any other state and comes up invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      code_q <= '0;
      timer  <= '0;
      cache  <= '0;
      age    <= READ_INTERVAL;
      resp0  <= '0;
      resp1  <= '0;
    end else begin
      timer <= (state_next != state || state == ST_IDLE) ? '0 : timer + 32'd1;
      if (state == ST_IDLE && bus.i_rx_valid)    addr_q <= bus.i_rx_data;
      if (state == ST_GET_CMD && bus.i_rx_valid) code_q <= bus.i_rx_data;
      if (read_done) begin
        cache.valid <= 1'b1;
        cache.addr  <= addr_q;
        age         <= '0;
        if (bus.i_sensor_done) begin
          cache.fault      <= bus.i_sensor_error;
          cache.hum_int    <= bus.i_hum_int;
          cache.hum_float  <= bus.i_hum_float;
          cache.temp_int   <= bus.i_temp_int;
          cache.temp_float <= bus.i_temp_float;
          cache.crc        <= bus.i_crc;
        end else begin
          cache.fault      <= 1'b1;
          cache.hum_int    <= '0;
          cache.hum_float  <= '0;
          cache.temp_int   <= '0;
          cache.temp_float <= '0;
          cache.crc        <= '0;
        end
      end else if (age < READ_INTERVAL) begin
        age <= age + 32'd1;
      end
      if (state == ST_BUILD) begin
        resp0 <= enc_byte0;
        resp1 <= enc_byte1;
      end
    end
  end

  sensor_resp_encoder u_encoder (
    .req_code   (code_q),
    .bad_addr   (bad_addr),
    .fault      (cache.fault),
    .hum_int    (cache.hum_int),
    .hum_float  (cache.hum_float),
    .temp_int   (cache.temp_int),
    .temp_float (cache.temp_float),
    .crc        (cache.crc),
    .byte0      (enc_byte0),
    .byte1      (enc_byte1)
  );

  always_comb begin
    bus.o_tx_data = 8'h00;
    if (state == ST_SEND0 || state == ST_HOLD0)      bus.o_tx_data = resp0;
    else if (state == ST_SEND1 || state == ST_HOLD1) bus.o_tx_data = resp1;
  end

  assign bus.o_sensor_addr = (state == ST_START || state == ST_WAIT_SENSOR) ? addr_q : 8'h00;
  assign bus.o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Scoreboard bench for sensor_request_scheduler with small timing parameters,
// a responding sensor model and a busy-for-a-while transmitter model.
module tb_sensor_request_scheduler;

  localparam int unsigned RI  = 300;
  localparam int unsigned STO = 60;
  localparam int unsigned RXT = 40;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  sensor_request_scheduler_if bus();

  sensor_request_scheduler #(
    .CLK_HZ(50_000_000), .READ_INTERVAL(RI), .SENSOR_TIMEOUT(STO),
    .RX_TIMEOUT(RXT), .N_SENSORS(32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_addr = 8'h00;
  int sensor_starts = 0, tx_starts = 0;
  bit prev_tx = 0, prev_ss = 0;
  bit force_busy = 0, sensor_respond = 1;
  logic [7:0] f_hi = 0, f_hf = 0, f_ti = 0, f_tf = 0, f_crc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every transmit pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.o_tx_start) begin
        tx_starts++;
        check("tx_start_width", {31'b0, prev_tx}, 0);
        check("tx_expected_pending", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) check("tx_byte", bus.o_tx_data, exp_q.pop_front());
      end
      if (bus.o_sensor_start) begin
        sensor_starts++;
        check("sensor_start_width", {31'b0, prev_ss}, 0);
        check("sensor_addr", bus.o_sensor_addr, exp_addr);
      end
      prev_tx = bus.o_tx_start;
      prev_ss = bus.o_sensor_start;
    end else begin
      prev_tx = 0;
      prev_ss = 0;
    end
  end

  // Transmitter and sensor-reader models, driven just after the rising edge.
  initial begin
    int busy_cnt = 0, tx_handled = 0, ss_handled = 0, pend = 0;
    forever begin
      @(posedge clock);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (tx_starts != tx_handled) begin tx_handled = tx_starts; busy_cnt = 4; end
      bus.i_tx_busy = force_busy || (busy_cnt != 0);
      bus.i_sensor_done  = 1'b0;
      bus.i_sensor_error = 1'b0;
      if (!reset_n) pend = 0;
      else if (sensor_starts != ss_handled) begin ss_handled = sensor_starts; pend = 3; end
      else if (pend > 0) begin
        pend--;
        if (pend == 0 && sensor_respond) begin
          bus.i_sensor_done = 1'b1;
          bus.i_hum_int = f_hi; bus.i_hum_float = f_hf;
          bus.i_temp_int = f_ti; bus.i_temp_float = f_tf; bus.i_crc = f_crc;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge clock); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while ((bus.o_busy || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    check({name, "_completes"}, {31'b0, n < max_cycles}, 1);
    if (n >= max_cycles) exp_q.delete();
  endtask

  task automatic transact(input string name, input logic [7:0] a, input logic [7:0] c,
                          input logic [7:0] e0, input logic [7:0] e1, input int reads);
    int s0 = sensor_starts;
    int t0 = tx_starts;
    exp_addr = a;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    send_byte(a);
    send_byte(c);
    wait_idle(name, 500);
    check({name, "_reads"}, sensor_starts - s0, reads);
    check({name, "_tx_count"}, tx_starts - t0, 2);
  endtask

  task automatic set_frame(input logic [7:0] hi, input logic [7:0] ti, input logic [7:0] crc);
    f_hi = hi; f_hf = 8'h00; f_ti = ti; f_tf = 8'h00; f_crc = crc;
  endtask

  initial begin
    int s0, t0;
    bus.i_rx_valid = 0; bus.i_rx_data = 0; bus.i_sensor_done = 0; bus.i_sensor_error = 0;
    bus.i_hum_int = 0; bus.i_hum_float = 0; bus.i_temp_int = 0; bus.i_temp_float = 0;
    bus.i_crc = 0; bus.i_tx_busy = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'b0, bus.o_busy}, 0);
    check("reset_sensor_start", {31'b0, bus.o_sensor_start}, 0);
    check("reset_tx_start", {31'b0, bus.o_tx_start}, 0);
    check("reset_tx_data", bus.o_tx_data, 0);
    reset_n = 1'b1;

    set_frame(8'd30, 8'd25, 8'd55);
    transact("cold_temp", 8'h00, 8'h04, 8'h09, 8'h19, 1);
    transact("cached_hum", 8'h00, 8'h05, 8'h0A, 8'h1E, 0);
    repeat (RI + 20) @(negedge clock);
    set_frame(8'd40, 8'd25, 8'd65);
    transact("stale_hum", 8'h00, 8'h05, 8'h0A, 8'h28, 1);

    set_frame(8'd40, 8'd25, 8'h00);
    transact("crc_bad_status", 8'h01, 8'h03, 8'h1F, 8'h00, 1);
    set_frame(8'd40, 8'd25, 8'd65);
    sensor_respond = 0;
    transact("timeout_status", 8'h02, 8'h03, 8'h1F, 8'h00, 1);
    sensor_respond = 1;
    transact("bad_addr", 8'h40, 8'h03, 8'hFE, 8'h00, 0);
    transact("bad_code", 8'h00, 8'h07, 8'hFF, 8'h00, 0);

    t0 = tx_starts;
    send_byte(8'h05);
    repeat (RXT + 10) @(negedge clock);
    check("rx_timeout_idle", {31'b0, bus.o_busy}, 0);
    check("rx_timeout_no_tx", tx_starts - t0, 0);
    transact("after_rx_timeout", 8'h03, 8'h03, 8'h08, 8'h00, 1);

    force_busy = 1;
    s0 = sensor_starts; t0 = tx_starts; exp_addr = 8'h03;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h19);
    send_byte(8'h03);
    send_byte(8'h04);
    repeat (100) @(negedge clock);
    check("busy_hold_no_start", tx_starts - t0, 0);
    check("busy_hold_pending", {31'b0, bus.o_busy}, 1);
    force_busy = 0;
    wait_idle("busy_release", 200);
    check("busy_release_reads", sensor_starts - s0, 0);
    check("busy_release_tx_count", tx_starts - t0, 2);

    sensor_respond = 0;
    s0 = sensor_starts; exp_addr = 8'h04;
    send_byte(8'h04);
    send_byte(8'h03);
    repeat (4) @(negedge clock);
    check("wait_sensor_addr_held", bus.o_sensor_addr, 8'h04);
    check("wait_sensor_read", sensor_starts - s0, 1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, bus.o_busy}, 0);
    check("midreset_sensor_addr", bus.o_sensor_addr, 0);
    check("midreset_sensor_start", {31'b0, bus.o_sensor_start}, 0);
    check("midreset_tx_start", {31'b0, bus.o_tx_start}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    sensor_respond = 1;
    transact("post_reset_miss", 8'h03, 8'h04, 8'h09, 8'h19, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
